// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx arbiter.
//   arb_state_e    : arbiter FSM state encoding (IDLE, START, SEND, RELEASE)
//   DEFAULT_DATA_W : default byte width, matching uart_tx
//   grant_w()      : width of a grant index for a given requester count
package uart_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StSend,
        StRelease
    } arb_state_e;

    localparam int unsigned DEFAULT_DATA_W = 8;

    function automatic int unsigned grant_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// The search starts at last_grant+1 (mod NUM_REQ) and takes the first valid
// requester, so the most recently served requester has the lowest priority.
// Ports:
//   req_valid  in  NUM_REQ : pending requests
//   last_grant in  IDX_W   : index of the previous winner
//   grant      out NUM_REQ : one-hot winner (all zero if nothing valid)
//   grant_idx  out IDX_W   : binary index of the winner
//   any_valid  out 1       : at least one request pending
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    logic [31:0] cand;
    logic        found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        // Offsets 1..NUM_REQ: the last winner itself is visited last.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(last_grant) + off) % NUM_REQ;
            if (!found && req_valid[cand[IDX_W-1:0]]) begin
                found                    = 1'b1;
                grant[cand[IDX_W-1:0]]   = 1'b1;
                grant_idx                = cand[IDX_W-1:0];
            end
        end
    end

    assign any_valid = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers.
// One byte is in flight at a time; the FSM follows the frame by watching the
// start bit on tx_line and the tx_done level, both resynchronised into clk.
// Optional feature macro: UART_ARB_TIMEOUT_EN adds a START/SEND watchdog and
// the err output.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : per-requester byte pending
//   req_data    : byte i at [i*DATA_W +: DATA_W]
//   req_ready   : one-cycle one-hot accept pulse
//   new_dat     : start request to uart_tx
//   tx_dat      : byte to uart_tx, stable while new_dat is high
//   tx_line     : uart_tx serial output (monitored)
//   tx_done     : uart_tx frame-complete level
//   grant_id    : index of the current or last granted requester
//   busy        : high in any state other than IDLE
//   err         : watchdog timeout pulse (UART_ARB_TIMEOUT_EN only)
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 131072
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      new_dat,
    output logic [DATA_W-1:0]         tx_dat,
    input  logic                      tx_line,
    input  logic                      tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                      busy
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                      err
`endif
);

    localparam int unsigned IDX_W = grant_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    // ------------------------------------------------------------------
    // Synchronisers for the monitored uart_tx signals
    // ------------------------------------------------------------------
    logic [1:0] line_sync;
    logic [1:0] done_sync;
    logic       done_prev;
    logic       line_s;
    logic       done_s;
    logic       done_rise;

    // The serial line idles high, so its synchroniser resets to 1 to avoid
    // a phantom start bit right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_sync <= 2'b11;
            done_sync <= 2'b00;
            done_prev <= 1'b0;
        end else begin
            line_sync <= {line_sync[0], tx_line};
            done_sync <= {done_sync[0], tx_done};
            done_prev <= done_sync[1];
        end
    end

    assign line_s    = line_sync[1];
    assign done_s    = done_sync[1];
    assign done_rise = done_s & ~done_prev;

    // ------------------------------------------------------------------
    // Round-robin pick
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   last_grant;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (pick),
        .grant_idx  (pick_idx),
        .any_valid  (any_valid)
    );

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_expired;

    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // ------------------------------------------------------------------
    // Arbiter FSM with registered outputs
    // ------------------------------------------------------------------
    arb_state_e state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            req_ready  <= '0;
            new_dat    <= 1'b0;
            tx_dat     <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            // Requester 0 is the first to be searched after reset.
            last_grant <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            err        <= 1'b0;
            wd_cnt     <= '0;
`endif
        end else begin
            req_ready <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            err       <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (any_valid) begin
                        tx_dat     <= req_data[pick_idx*DATA_W +: DATA_W];
                        grant_id   <= pick_idx;
                        last_grant <= pick_idx;
                        req_ready  <= pick;
                        new_dat    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= StStart;
`ifdef UART_ARB_TIMEOUT_EN
                        wd_cnt     <= '0;
`endif
                    end
                end
                StStart: begin
                    // Start bit observed: uart_tx has latched the byte.
                    if (!line_s) begin
                        new_dat <= 1'b0;
                        state   <= StSend;
                    end
                end
                StSend: begin
                    if (done_rise) begin
                        state <= StRelease;
                    end
                end
                StRelease: begin
                    // Wait for the done level to clear so it cannot be
                    // mistaken for the end of the next frame.
                    if (!done_s) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: begin
                    new_dat <= 1'b0;
                    busy    <= 1'b0;
                    state   <= StIdle;
                end
            endcase

`ifdef UART_ARB_TIMEOUT_EN
            // Placed after the case so an expiry overrides any transition.
            if (state == StStart || state == StSend) begin
                if (wd_expired) begin
                    new_dat <= 1'b0;
                    busy    <= 1'b0;
                    err     <= 1'b1;
                    state   <= StIdle;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 8;
    localparam int TIMEOUT  = 64;
    localparam int BIT_T    = 16;
    localparam int DONE_LEN = 4;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      new_dat;
    logic [DATA_W-1:0]         tx_dat;
    logic                      tx_line = 1'b1;
    logic                      tx_done = 1'b0;
    logic [1:0]                grant_id;
    logic                      busy;
`ifdef UART_ARB_TIMEOUT_EN
    logic                      err;
`endif

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .new_dat   (new_dat),
        .tx_dat    (tx_dat),
        .tx_line   (tx_line),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- uart_tx behavioural model ----------------
    logic       uart_en = 1'b1;
    logic       uart_busy = 1'b0;
    logic [7:0] frame_byte;
    logic [7:0] frames[$];
    int         line_fall_cyc = 0;

    initial forever begin
        @(posedge clk);
        if (uart_en && rst_n && new_dat) begin
            frame_byte = tx_dat;
            uart_busy  = 1'b1;
            frames.push_back(frame_byte);
            #1;
            tx_line = 1'b0;
            line_fall_cyc = cyc;
            repeat (BIT_T) @(posedge clk);
            #1;
            for (int k = 0; k < 8; k++) begin
                tx_line = frame_byte[k];
                repeat (BIT_T) @(posedge clk);
                #1;
            end
            tx_line = 1'b1;
            repeat (BIT_T) @(posedge clk);
            #1;
            tx_done = 1'b1;
            repeat (DONE_LEN) @(posedge clk);
            #1;
            tx_done   = 1'b0;
            uart_busy = 1'b0;
        end
    end

    // ---------------- grant monitor ----------------
    int         g_idx[$];
    logic [7:0] g_dat[$];
    int         g_gid[$];
    int         bad_onehot = 0;
    int         dat_unstable = 0;
    logic       prev_nd = 1'b0;
    logic [7:0] prev_dat = '0;

    initial forever begin
        @(negedge clk);
        if (req_ready != '0) begin
            if ($countones(req_ready) != 1) bad_onehot++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    g_idx.push_back(i);
                    g_dat.push_back(tx_dat);
                    g_gid.push_back(int'(grant_id));
                    break;
                end
            end
        end
        if (new_dat && prev_nd && tx_dat !== prev_dat) dat_unstable++;
        prev_nd  = new_dat;
        prev_dat = tx_dat;
    end

    // ---------------- producers ----------------
    logic [7:0] pbuf[NUM_REQ][16];
    int         pcnt[NUM_REQ];
    int         pidx[NUM_REQ];

    task automatic clear_producers();
        for (int i = 0; i < NUM_REQ; i++) begin
            pcnt[i] = 0;
            pidx[i] = 0;
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = (pidx[i] < pcnt[i]);
            req_data[i*DATA_W +: DATA_W] = (pidx[i] < pcnt[i]) ? pbuf[i][pidx[i]] : 8'h00;
        end
    endtask

    function automatic bit all_sent();
        for (int i = 0; i < NUM_REQ; i++) if (pidx[i] < pcnt[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_producers(input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        drive_reqs();
        while (n < budget) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) pidx[i]++;
            drive_reqs();
            if (all_sent() && !busy && !uart_busy && !new_dat && !tx_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_uart_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!uart_busy && !tx_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        g_idx.delete();
        g_dat.delete();
        g_gid.delete();
        frames.delete();
    endtask

    task automatic do_reset();
        bit ok;
        req_valid = '0;
        wait_uart_idle(ok);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_producers();
        clear_logs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (new_dat !== 1'b0) begin errors++; $display("FAIL reset_new_dat: got %b expected 0", new_dat); end
        checks++; if (tx_dat !== 8'h00) begin errors++; $display("FAIL reset_tx_dat: got %h expected 00", tx_dat); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef UART_ARB_TIMEOUT_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
    endtask

    task automatic test_single();
        bit ok;
        int fall_seen;
        do_reset();
        pcnt[1] = 1;
        pbuf[1][0] = 8'hA5;
        drive_reqs();
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
        checks++; if (new_dat !== 1'b1) begin errors++; $display("FAIL single_new_dat_rise: got %b expected 1", new_dat); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b expected 1", busy); end
        checks++; if (tx_dat !== 8'hA5) begin errors++; $display("FAIL single_tx_dat: got %h expected a5", tx_dat); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_grant_id: got %0d expected 1", grant_id); end
        if (req_ready[1]) pidx[1]++;
        drive_reqs();
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_width: got %b expected 0000", req_ready); end
        fall_seen = 0;
        for (int n = 0; n < 200; n++) begin
            if (!new_dat) begin
                fall_seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (fall_seen != 1) begin errors++; $display("FAIL single_new_dat_fall: got no fall expected fall"); end
        checks++; if (tx_line !== 1'b0) begin errors++; $display("FAIL single_new_dat_hold: line %b at fall expected 0", tx_line); end
        checks++; if (cyc - line_fall_cyc != 3) begin errors++; $display("FAIL single_fall_latency: got %0d expected 3", cyc - line_fall_cyc); end
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (tx_done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!(ok && busy === 1'b1)) begin errors++; $display("FAIL single_busy_at_done: got %b expected 1", busy); end
        run_producers(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_finish: got timeout expected idle"); end
        checks++; if (frames.size() != 1) begin errors++; $display("FAIL single_frame_count: got %0d expected 1", frames.size()); end
        else begin
            checks++; if (frames[0] !== 8'hA5) begin errors++; $display("FAIL single_frame_byte: got %h expected a5", frames[0]); end
        end
        checks++; if (dat_unstable != 0) begin errors++; $display("FAIL single_tx_dat_stable: got %0d changes expected 0", dat_unstable); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        pcnt[0] = 1; pbuf[0][0] = 8'h11;
        pcnt[2] = 1; pbuf[2][0] = 8'h22;
        run_producers(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_finish: got timeout expected idle"); end
        checks++; if (g_idx.size() != 2 || frames.size() != 2) begin
            errors++; $display("FAIL simul_count: got %0d grants %0d frames expected 2 2", g_idx.size(), frames.size());
        end else begin
            checks++; if (g_idx[0] != 0 || g_idx[1] != 2) begin errors++; $display("FAIL simul_order: got %0d,%0d expected 0,2", g_idx[0], g_idx[1]); end
            checks++; if (frames[0] !== 8'h11 || frames[1] !== 8'h22) begin errors++; $display("FAIL simul_frames: got %h,%h expected 11,22", frames[0], frames[1]); end
        end
        checks++; if (bad_onehot != 0) begin errors++; $display("FAIL simul_onehot: got %0d bad expected 0", bad_onehot); end
    endtask

    task automatic test_fairness();
        bit ok;
        int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            pcnt[i] = 2;
            pbuf[i][0] = 8'($urandom);
            pbuf[i][1] = 8'($urandom);
        end
        run_producers(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fair_finish: got timeout expected idle"); end
        checks++; if (g_idx.size() != 8) begin errors++; $display("FAIL fair_count: got %0d expected 8", g_idx.size()); end
        else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (g_idx[k] != exp_seq[k] || g_gid[k] != exp_seq[k] ||
                    g_dat[k] !== pbuf[exp_seq[k]][k/4]) begin
                    errors++;
                    $display("FAIL fair_grant_%0d: got id %0d gid %0d dat %h expected id %0d dat %h",
                             k, g_idx[k], g_gid[k], g_dat[k], exp_seq[k], pbuf[exp_seq[k]][k/4]);
                end
            end
        end
    endtask

    // Transaction-level model: at every idle point, the first requester with
    // bytes left, scanning upward from the previous winner, is served next.
    task automatic test_back_to_back();
        bit ok;
        int last = NUM_REQ - 1;
        int rem[NUM_REQ];
        int exp_id[$];
        logic [7:0] exp_dat[$];
        do_reset();
        for (int round = 0; round < 3; round++) begin
            clear_producers();
            clear_logs();
            exp_id.delete();
            exp_dat.delete();
            for (int i = 0; i < NUM_REQ; i++) begin
                pcnt[i] = $urandom_range(0, 3);
                for (int j = 0; j < pcnt[i]; j++) pbuf[i][j] = 8'($urandom);
                rem[i] = pcnt[i];
            end
            if (pcnt[round] == 0) begin
                pcnt[round] = 1;
                pbuf[round][0] = 8'($urandom);
                rem[round] = 1;
            end
            forever begin
                int pick = -1;
                for (int off = 1; off <= NUM_REQ; off++) begin
                    int c = (last + off) % NUM_REQ;
                    if (rem[c] > 0) begin
                        pick = c;
                        break;
                    end
                end
                if (pick < 0) break;
                exp_id.push_back(pick);
                exp_dat.push_back(pbuf[pick][pcnt[pick] - rem[pick]]);
                rem[pick]--;
                last = pick;
            end
            run_producers(4000, ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_finish_r%0d: got timeout expected idle", round); end
            checks++;
            if (g_idx.size() != exp_id.size() || frames.size() != exp_id.size()) begin
                errors++;
                $display("FAIL b2b_count_r%0d: got %0d grants %0d frames expected %0d",
                         round, g_idx.size(), frames.size(), exp_id.size());
            end else begin
                for (int k = 0; k < exp_id.size(); k++) begin
                    checks++;
                    if (g_idx[k] != exp_id[k] || g_dat[k] !== exp_dat[k] || frames[k] !== exp_dat[k]) begin
                        errors++;
                        $display("FAIL b2b_r%0d_%0d: got id %0d dat %h frame %h expected id %0d dat %h",
                                 round, k, g_idx[k], g_dat[k], frames[k], exp_id[k], exp_dat[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_withdraw();
        bit ok;
        do_reset();
        pcnt[0] = 1; pbuf[0][0] = 8'h3C;
        drive_reqs();
        @(negedge clk);
        if (req_ready[0]) pidx[0]++;
        drive_reqs();
        repeat (20) @(negedge clk);
        req_valid[3] = 1'b1;
        req_data[3*DATA_W +: DATA_W] = 8'h99;
        repeat (30) @(negedge clk);
        req_valid[3] = 1'b0;
        run_producers(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL withdraw_finish: got timeout expected idle"); end
        checks++; if (g_idx.size() != 1 || frames.size() != 1) begin
            errors++; $display("FAIL withdraw_count: got %0d grants %0d frames expected 1 1", g_idx.size(), frames.size());
        end else begin
            checks++; if (g_idx[0] != 0 || frames[0] !== 8'h3C) begin errors++; $display("FAIL withdraw_content: got id %0d frame %h expected 0 3c", g_idx[0], frames[0]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int fell = 0;
        do_reset();
        pcnt[2] = 1; pbuf[2][0] = 8'h5A;
        drive_reqs();
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rstmid_grant: got %b expected 0100", req_ready); end
        if (req_ready[2]) pidx[2]++;
        drive_reqs();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!new_dat) begin
                fell = 1;
                break;
            end
        end
        repeat (10) @(negedge clk);
        checks++; if (!(fell == 1 && busy === 1'b1)) begin errors++; $display("FAIL rstmid_in_send: got busy %b expected 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (new_dat !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0) begin
            errors++; $display("FAIL rstmid_async: got new_dat %b busy %b ready %b expected 0 0 0000", new_dat, busy, req_ready);
        end
        checks++; if (tx_dat !== 8'h00 || grant_id !== 2'd0) begin errors++; $display("FAIL rstmid_regs: got %h %0d expected 00 0", tx_dat, grant_id); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_uart_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_uart_idle: got timeout expected idle"); end
        clear_producers();
        clear_logs();
        pcnt[0] = 1; pbuf[0][0] = 8'h01;
        pcnt[3] = 1; pbuf[3][0] = 8'h03;
        run_producers(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_finish: got timeout expected idle"); end
        checks++; if (g_idx.size() != 2) begin errors++; $display("FAIL rstmid_count: got %0d expected 2", g_idx.size()); end
        else begin
            checks++; if (g_idx[0] != 0 || g_idx[1] != 3) begin errors++; $display("FAIL rstmid_order: got %0d,%0d expected 0,3", g_idx[0], g_idx[1]); end
        end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int g_cyc;
        int e_cyc = -1;
        do_reset();
        uart_en = 1'b0;
        tx_line = 1'b1;
        pcnt[1] = 1; pbuf[1][0] = 8'h77;
        drive_reqs();
        @(negedge clk);
        g_cyc = cyc;
        if (req_ready[1]) pidx[1]++;
        drive_reqs();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (err) begin
                e_cyc = cyc;
                break;
            end
        end
        checks++; if (e_cyc - g_cyc != TIMEOUT) begin errors++; $display("FAIL timeout_delay: got %0d expected %0d", e_cyc - g_cyc, TIMEOUT); end
        checks++; if (new_dat !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_state: got new_dat %b busy %b expected 0 0", new_dat, busy); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b expected 0", err); end
        uart_en = 1'b1;
        run_producers(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_idle: got timeout expected idle"); end
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL global_watchdog: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        clear_producers();
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_back_to_back();
        test_withdraw();
        test_reset_mid_frame();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
